// File: rtl/ccd_fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter family.
// State constants stay plain 2-bit localparams so older netlists can compare encodings directly.
package ccd_fifo_rd_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_BURST = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_BURST_LEN = 8;
   localparam int CNT_W         = $clog2(DEF_BURST_LEN + 1);
   localparam int PTR_W         = $clog2(DEF_NUM_REQ);
   localparam int MAX_REQ       = 32;

   // Callers size-cast the result down to their own requester count.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [31:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/ccd_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
// N need not be a power of two; ptr is assumed to be below N.
module ccd_rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          valid
);

   int j;

   // Scan from the far end back toward ptr so the closest candidate is written last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (req[j]) begin
            idx   = PW'(j);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ccd_fifo_rd_arbiter.sv
// Shares one async-FIFO read port among NUM_REQ consumers, round-robin, in bursts of up to BURST_LEN pops.
// Popped words come back one cycle later on out_data, tagged by a one-hot out_valid.
module ccd_fifo_rd_arbiter
   import ccd_fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rstn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [NUM_REQ-1:0]    out_valid,
   output logic                  busy,
   output logic [1:0]            fsm_state
);

   localparam int CNT_BITS = $clog2(BURST_LEN + 1);
   localparam int PTR_BITS = $clog2(NUM_REQ);

   state_t              state;
   logic [PTR_BITS-1:0] owner;
   logic [PTR_BITS-1:0] ptr;
   logic [PTR_BITS-1:0] tag;
   logic [PTR_BITS-1:0] pick_idx;
   logic                pick_valid;
   logic [CNT_BITS-1:0] cnt;
   logic                pend;
   logic                pop;

   ccd_rr_pick #(
      .N  (NUM_REQ),
      .PW (PTR_BITS)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // A pop only happens while the owner still asks and the FIFO has data.
   assign pop       = (state == ST_BURST) && req[owner] && !empty;
   assign rd_en     = pop;
   assign busy      = (state == ST_BURST) || (state == ST_DRAIN);
   assign fsm_state = state;

   always_ff @(posedge rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         state <= ST_IDLE;
         gnt   <= '0;
         owner <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  owner <= pick_idx;
                  gnt   <= NUM_REQ'(onehot(32'(pick_idx)));
                  cnt   <= '0;
                  state <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (!req[owner]) begin
                  state <= ST_DRAIN;
               end else if (pop) begin
                  cnt <= cnt + CNT_BITS'(1);
                  if (cnt == CNT_BITS'(BURST_LEN - 1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Pointer moves past the owner only once its turn is over, however it ended.
               gnt   <= '0;
               ptr   <= (owner == PTR_BITS'(NUM_REQ - 1)) ? '0 : owner + PTR_BITS'(1);
               state <= ST_IDLE;
            end
            default: begin
               gnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Return pipe: the FIFO presents the word the cycle after the pop; register it with its owner tag.
   always_ff @(posedge rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         pend      <= 1'b0;
         tag       <= '0;
         out_data  <= '0;
         out_valid <= '0;
      end else begin
         pend <= pop;
         if (pop) tag <= owner;
         if (pend) begin
            out_data  <= rd_data;
            out_valid <= NUM_REQ'(onehot(32'(tag)));
         end else begin
            out_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ccd_fifo_rd_arbiter.sv
// Bench for ccd_fifo_rd_arbiter: a 4-requester and a 3-requester instance, each fed by a simple FIFO model.
// Valid/ready: a word is consumed on a rising clock when rd_en is high; the FIFO shows it on rd_data one cycle later.
module tb_ccd_fifo_rd_arbiter;

   logic clk = 1'b0;
   logic rd_rstn = 1'b0;

   // 4-requester instance
   logic [3:0]  req4 = '0;
   logic        empty4 = 1'b1;
   logic [15:0] rd_data4 = '0;
   logic        rd_en4;
   logic [3:0]  gnt4;
   logic [15:0] od4;
   logic [3:0]  ov4;
   logic        busy4;
   logic [1:0]  st4;

   // 3-requester instance
   logic [2:0]  req3 = '0;
   logic        empty3 = 1'b1;
   logic [15:0] rd_data3 = '0;
   logic        rd_en3;
   logic [2:0]  gnt3;
   logic [15:0] od3;
   logic [2:0]  ov3;
   logic        busy3;
   logic [1:0]  st3;

   // FIFO models: word n of a fill reads as base + n
   int          idx4 = 0, len4 = 0, idx3 = 0, len3 = 0;
   logic [15:0] base4 = '0, base3 = '0;
   logic        stall4 = 1'b0, toggle4 = 1'b0;

   logic [19:0] exp4_q[$];
   logic [18:0] exp3_q[$];
   int          checks = 0;
   int          failures = 0;

   bit          sel3 = 1'b0;
   logic [3:0]  gnt_m;
   logic [1:0]  st_m;
   int          idx_m;

   ccd_fifo_rd_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .BURST_LEN(8)) dut4 (
      .rd_clk(clk), .rd_rstn(rd_rstn), .req(req4), .empty(empty4), .rd_data(rd_data4),
      .rd_en(rd_en4), .gnt(gnt4), .out_data(od4), .out_valid(ov4), .busy(busy4), .fsm_state(st4)
   );

   ccd_fifo_rd_arbiter #(.DATA_WIDTH(16), .NUM_REQ(3), .BURST_LEN(8)) dut3 (
      .rd_clk(clk), .rd_rstn(rd_rstn), .req(req3), .empty(empty3), .rd_data(rd_data3),
      .rd_en(rd_en3), .gnt(gnt3), .out_data(od3), .out_valid(ov3), .busy(busy3), .fsm_state(st3)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   always_comb begin
      gnt_m = sel3 ? {1'b0, gnt3} : gnt4;
      st_m  = sel3 ? st3 : st4;
      idx_m = sel3 ? idx3 : idx4;
   end

   // ---------------- FIFO models ----------------
   always @(posedge clk) begin
      if (!rd_rstn) begin
         idx4 <= 0;
         idx3 <= 0;
      end else begin
         if (rd_en4) begin
            rd_data4 <= base4 + 16'(idx4);
            idx4     <= idx4 + 1;
         end
         if (rd_en3) begin
            rd_data3 <= base3 + 16'(idx3);
            idx3     <= idx3 + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (toggle4) stall4 = ~stall4;
      else stall4 = 1'b0;
      empty4 = stall4 | (idx4 >= len4);
      empty3 = (idx3 >= len3);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout actual=none required=event", name);
   endtask

   task automatic wait_gnt(input bit nz, input string name);
      int n = 0;
      tick();
      while (((gnt_m != 0) != nz) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) timeout(name);
   endtask

   task automatic wait_idx(input int target, input string name);
      int n = 0;
      tick();
      while (idx_m < target && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) timeout(name);
   endtask

   task automatic wait_state(input logic [1:0] s, input string name);
      int n = 0;
      tick();
      while (st_m != s && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) timeout(name);
   endtask

   task automatic restart(input logic [15:0] b4, input int l4, input logic [15:0] b3, input int l3);
      tick();
      rd_rstn = 1'b0;
      req4 = '0;
      req3 = '0;
      toggle4 = 1'b0;
      base4 = b4;
      len4 = l4;
      base3 = b3;
      len3 = l3;
      tick();
      tick();
      rd_rstn = 1'b1;
   endtask

   task automatic drain_check(input string name);
      repeat (4) tick();
      chk(name, 32'(exp4_q.size() + exp3_q.size()), 32'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [19:0] e4;
      logic [18:0] e3;
      #1;
      if (rd_rstn) begin
         if (rd_en4) begin
            checks++;
            if (empty4) begin
               failures++;
               $display("FAIL rd_en_empty4 actual=rd_en=1,empty=1 required=rd_en=0");
            end
         end
         if (rd_en3) begin
            checks++;
            if (empty3) begin
               failures++;
               $display("FAIL rd_en_empty3 actual=rd_en=1,empty=1 required=rd_en=0");
            end
         end
         if (ov4 != '0) begin
            checks++;
            if (exp4_q.size() == 0) begin
               failures++;
               $display("FAIL sb4_unexpected actual=%0h/%0h required=no output", ov4, od4);
            end else begin
               e4 = exp4_q.pop_front();
               if ({ov4, od4} !== e4) begin
                  failures++;
                  $display("FAIL sb4_word actual=%0h/%0h required=%0h/%0h", ov4, od4, e4[19:16], e4[15:0]);
               end
            end
         end
         if (ov3 != '0) begin
            checks++;
            if (exp3_q.size() == 0) begin
               failures++;
               $display("FAIL sb3_unexpected actual=%0h/%0h required=no output", ov3, od3);
            end else begin
               e3 = exp3_q.pop_front();
               if ({ov3, od3} !== e3) begin
                  failures++;
                  $display("FAIL sb3_word actual=%0h/%0h required=%0h/%0h", ov3, od3, e3[18:16], e3[15:0]);
               end
            end
         end
      end
   end

   // ---------------- directed tests ----------------
   initial begin
      logic [3:0] oh4;
      logic [2:0] oh3;

      // T1: reset values, then reset asserted with a pop in flight
      tick();
      tick();
      chk("rst_gnt", 32'(gnt4), 32'h0);
      chk("rst_rd_en", 32'(rd_en4), 32'h0);
      chk("rst_out_valid", 32'(ov4), 32'h0);
      chk("rst_out_data", 32'(od4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      chk("rst_state", 32'(st4), 32'h0);
      restart(16'h1000, 20, 16'h0, 0);
      req4 = 4'b0001;
      wait_gnt(1'b1, "t1_gnt");
      chk("t1_gnt_val", 32'(gnt4), 32'h1);
      tick();
      chk("t1_rd_en", 32'(rd_en4), 32'h1);
      @(posedge clk);
      #2;
      rd_rstn = 1'b0;
      tick();
      chk("t1_mid_gnt", 32'(gnt4), 32'h0);
      chk("t1_mid_out_valid", 32'(ov4), 32'h0);
      chk("t1_mid_busy", 32'(busy4), 32'h0);
      chk("t1_mid_rd_en", 32'(rd_en4), 32'h0);
      req4 = '0;
      tick();
      rd_rstn = 1'b1;
      drain_check("t1_no_stray");

      // T2: lone requester 2, two full bursts with re-grant
      restart(16'h2000, 20, 16'h0, 0);
      for (int i = 0; i < 16; i++) exp4_q.push_back({4'b0100, 16'h2000 + 16'(i)});
      req4 = 4'b0100;
      wait_gnt(1'b1, "t2_gnt_a");
      chk("t2_gnt_a", 32'(gnt4), 32'h4);
      chk("t2_busy", 32'(busy4), 32'h1);
      wait_gnt(1'b0, "t2_end_a");
      chk("t2_pops_a", 32'(idx4), 32'd8);
      wait_gnt(1'b1, "t2_gnt_b");
      chk("t2_gnt_b", 32'(gnt4), 32'h4);
      wait_idx(16, "t2_idx16");
      req4 = '0;
      wait_gnt(1'b0, "t2_end_b");
      chk("t2_pops_b", 32'(idx4), 32'd16);
      drain_check("t2_drain");
      chk("t2_no_more_pops", 32'(idx4), 32'd16);

      // T3: all requesters, grants rotate 0,1,2,3,0
      restart(16'h3000, 200, 16'h0, 0);
      for (int i = 0; i < 40; i++) begin
         oh4 = 4'b0001 << ((i / 8) % 4);
         exp4_q.push_back({oh4, 16'h3000 + 16'(i)});
      end
      req4 = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(1'b1, "t3_gnt");
         oh4 = 4'b0001 << (g % 4);
         chk("t3_gnt_order", 32'(gnt4), 32'(oh4));
         wait_gnt(1'b0, "t3_end");
         if (g == 4) req4 = '0;
      end
      chk("t3_pops", 32'(idx4), 32'd40);
      drain_check("t3_drain");

      // T4: empty toggles while requester 1 bursts
      restart(16'h4000, 100, 16'h0, 0);
      for (int i = 0; i < 8; i++) exp4_q.push_back({4'b0010, 16'h4000 + 16'(i)});
      toggle4 = 1'b1;
      req4 = 4'b0010;
      wait_gnt(1'b1, "t4_gnt");
      chk("t4_gnt", 32'(gnt4), 32'h2);
      wait_gnt(1'b0, "t4_end");
      req4 = '0;
      toggle4 = 1'b0;
      chk("t4_pops", 32'(idx4), 32'd8);
      drain_check("t4_drain");

      // T5: requester 3 quits after 3 pops, requester 0 goes next
      restart(16'h5000, 100, 16'h0, 0);
      for (int i = 0; i < 3; i++) exp4_q.push_back({4'b1000, 16'h5000 + 16'(i)});
      for (int i = 3; i < 11; i++) exp4_q.push_back({4'b0001, 16'h5000 + 16'(i)});
      req4 = 4'b1000;
      wait_gnt(1'b1, "t5_gnt3");
      chk("t5_gnt3", 32'(gnt4), 32'h8);
      wait_idx(3, "t5_idx3");
      req4 = 4'b0001;
      wait_state(2'd2, "t5_drain_state");
      chk("t5_last_in_drain", 32'(ov4), 32'h8);
      chk("t5_last_data", 32'(od4), 32'h5002);
      wait_gnt(1'b1, "t5_gnt0");
      chk("t5_gnt0", 32'(gnt4), 32'h1);
      chk("t5_pops_owner3", 32'(idx4), 32'd3);
      wait_gnt(1'b0, "t5_end");
      req4 = '0;
      chk("t5_pops_total", 32'(idx4), 32'd11);
      drain_check("t5_drain");

      // T6: three requesters, requests on 0 and 2, pointer wraps 2 -> 0
      restart(16'h0, 0, 16'h6000, 200);
      sel3 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         oh3 = ((i / 8) % 2 == 1) ? 3'b100 : 3'b001;
         exp3_q.push_back({oh3, 16'h6000 + 16'(i)});
      end
      req3 = 3'b101;
      for (int g = 0; g < 4; g++) begin
         wait_gnt(1'b1, "t6_gnt");
         oh3 = (g % 2 == 1) ? 3'b100 : 3'b001;
         chk("t6_gnt_order", 32'(gnt3), 32'(oh3));
         wait_gnt(1'b0, "t6_end");
         if (g == 3) req3 = '0;
      end
      chk("t6_pops", 32'(idx3), 32'd32);
      drain_check("t6_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
